// File: rtl/wide_adder_seq.sv
// Multi-cycle WIDTH-bit adder that walks 16-bit slices through a pair of 16-bit CLA adders.
// Define WIDE_ADDER_SEQ_SUB_EN to add the op_sub port (two's-complement subtract).

module adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Two-level lookahead: 4-bit group generate/propagate, then carries within each group.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < 4; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = &p[4*j +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c[4*j] = grp_c[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[16] = grp_c[4];
    end

    assign sum_o  = p ^ c[15:0];
    assign cout_o = c[16];
endmodule

module wide_adder_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef WIDE_ADDER_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CHUNKS = WIDTH / 16;
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((WIDTH < 16) || ((WIDTH % 16) != 0)) begin : g_width_check
        $error("wide_adder_seq: WIDTH must be a multiple of 16 and at least 16");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                   state_q, state_d;
    logic [CHUNKS-1:0][15:0]  a_q, a_d;
    logic [CHUNKS-1:0][15:0]  b_q, b_d;
    logic [CHUNKS-1:0][15:0]  sum_q, sum_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;

    logic [15:0] s1;
    logic [15:0] s2;
    logic        c1;
    logic        c2;
    logic        sub_in;

`ifdef WIDE_ADDER_SEQ_SUB_EN
    assign sub_in = op_sub;
`else
    assign sub_in = 1'b0;
`endif

    adder u_add_ab (
        .a_i    (a_q[cnt_q]),
        .b_i    (b_q[cnt_q]),
        .sum_o  (s1),
        .cout_o (c1)
    );

    adder u_add_carry (
        .a_i    (s1),
        .b_i    ({15'b0, carry_q}),
        .sum_o  (s2),
        .cout_o (c2)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b here and seed the carry chain with 1.
                    a_d     = a;
                    b_d     = sub_in ? ~b : b;
                    carry_d = sub_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                sum_d[cnt_q] = s2;
                carry_d      = c1 | c2;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CW'(CHUNKS - 1)) begin
                    cout_d  = c1 | c2;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_wide_adder_seq.sv
// Self-checking bench for wide_adder_seq at WIDTH=64 and WIDTH=16 against an arithmetic model.
// Subtract scenarios are compiled in when WIDE_ADDER_SEQ_SUB_EN is defined.

module tb_wide_adder_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
`ifdef WIDE_ADDER_SEQ_SUB_EN
    logic        op_sub;
`endif
    logic        in_valid64, in_ready64, out_valid64, out_ready64, cout64;
    logic [63:0] sum64;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16;
    logic [15:0] sum16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wide_adder_seq #(.WIDTH(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .a         (a),
        .b         (b),
`ifdef WIDE_ADDER_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .sum       (sum64),
        .cout      (cout64)
    );

    wide_adder_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a[15:0]),
        .b         (b[15:0]),
`ifdef WIDE_ADDER_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16)
    );

    // Drives one operation and collects the result; performs no comparisons itself.
    task automatic run_op(input bit w16, input logic [63:0] ta, input logic [63:0] tb,
                          input bit tsub, input bit hold_rdy, input int stall,
                          output logic [63:0] rs, output logic rc, output int lat,
                          output bit tmo);
        a = ta;
        b = tb;
`ifdef WIDE_ADDER_SEQ_SUB_EN
        op_sub = tsub;
`else
        if (tsub) $display("note: subtract requested without SUB_EN build");
`endif
        if (w16) begin
            in_valid16 = 1'b1; out_ready16 = hold_rdy;
        end else begin
            in_valid64 = 1'b1; out_ready64 = hold_rdy;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        in_valid64 = 1'b0;
        lat = 0;
        tmo = 1'b0;
        while (!(w16 ? out_valid16 : out_valid64) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(w16 ? out_valid16 : out_valid64)) begin
            tmo = 1'b1;
            rs  = '0;
            rc  = 1'b0;
            out_ready16 = 1'b0;
            out_ready64 = 1'b0;
            return;
        end
        rs = w16 ? {48'b0, sum16} : sum64;
        rc = w16 ? cout16 : cout64;
        if (!hold_rdy) begin
            repeat (stall) begin
                @(posedge clk); #1;
            end
            if (w16) out_ready16 = 1'b1;
            else     out_ready64 = 1'b1;
        end
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        out_ready64 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 8;
        if (in_ready64 !== 1'b1) begin bad++; $display("FAIL reset_in_ready64 got=%b exp=1", in_ready64); end
        if (out_valid64 !== 1'b0) begin bad++; $display("FAIL reset_out_valid64 got=%b exp=0", out_valid64); end
        if (sum64 !== 64'h0) begin bad++; $display("FAIL reset_sum64 got=%h exp=0", sum64); end
        if (cout64 !== 1'b0) begin bad++; $display("FAIL reset_cout64 got=%b exp=0", cout64); end
        if (in_ready16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready16 got=%b exp=1", in_ready16); end
        if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b exp=0", out_valid16); end
        if (sum16 !== 16'h0) begin bad++; $display("FAIL reset_sum16 got=%h exp=0", sum16); end
        if (cout16 !== 1'b0) begin bad++; $display("FAIL reset_cout16 got=%b exp=0", cout16); end
        rst = 1'b0;
    endtask

    task automatic test_carry_ripple();
        logic [63:0] rs;
        logic        rc;
        int          lat;
        bit          tmo;
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 0, rs, rc, lat, tmo);
        total += 4;
        if (tmo) begin bad++; $display("FAIL ripple_timeout got=timeout exp=out_valid"); end
        if (lat != 4) begin bad++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
        if (rs !== 64'h0) begin bad++; $display("FAIL ripple_sum got=%h exp=0", rs); end
        if (rc !== 1'b1) begin bad++; $display("FAIL ripple_cout got=%b exp=1", rc); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_sum;
        int          n;
        exp_sum = 64'h0000_0003_0001_0000;
        a = 64'h0000_0001_0000_FFFF;
        b = 64'h0000_0002_0000_0001;
`ifdef WIDE_ADDER_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        in_valid64  = 1'b1;
        out_ready64 = 1'b0;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        n = 0;
        while (!out_valid64 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!out_valid64) begin bad++; $display("FAIL bp_timeout got=timeout exp=out_valid"); end
        for (int i = 0; i < 10; i++) begin
            in_valid64 = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk); #1;
            total += 4;
            if (sum64 !== exp_sum) begin bad++; $display("FAIL bp_sum[%0d] got=%h exp=%h", i, sum64, exp_sum); end
            if (cout64 !== 1'b0) begin bad++; $display("FAIL bp_cout[%0d] got=%b exp=0", i, cout64); end
            if (out_valid64 !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid64); end
            if (in_ready64 !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready64); end
        end
        in_valid64  = 1'b0;
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        out_ready64 = 1'b0;
        total += 3;
        if (out_valid64 !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid64); end
        if (in_ready64 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready64); end
        if (sum64 !== exp_sum) begin bad++; $display("FAIL bp_idle_hold got=%h exp=%h", sum64, exp_sum); end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] rs;
        logic        rc;
        int          lat;
        bit          tmo;
        bit          seen;
        a = 64'h1111_2222_3333_4444;
        b = 64'h0101_0202_0303_0404;
`ifdef WIDE_ADDER_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        in_valid64  = 1'b1;
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total += 4;
        if (in_ready64 !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready64); end
        if (out_valid64 !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid64); end
        if (sum64 !== 64'h0) begin bad++; $display("FAIL abort_sum got=%h exp=0", sum64); end
        if (cout64 !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b exp=0", cout64); end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid64) seen = 1'b1;
        end
        out_ready64 = 1'b0;
        total++;
        if (seen) begin bad++; $display("FAIL abort_no_pulse got=pulse exp=none"); end
        run_op(1'b0, 64'd3, 64'd4, 1'b0, 1'b0, 1, rs, rc, lat, tmo);
        total += 3;
        if (tmo) begin bad++; $display("FAIL after_abort_timeout got=timeout exp=out_valid"); end
        if (rs !== 64'd7) begin bad++; $display("FAIL after_abort_sum got=%h exp=7", rs); end
        if (rc !== 1'b0) begin bad++; $display("FAIL after_abort_cout got=%b exp=0", rc); end
    endtask

`ifdef WIDE_ADDER_SEQ_SUB_EN
    task automatic test_sub();
        logic [63:0] rs;
        logic        rc;
        int          lat;
        bit          tmo;
        run_op(1'b0, 64'd5, 64'd7, 1'b1, 1'b1, 0, rs, rc, lat, tmo);
        total += 3;
        if (tmo) begin bad++; $display("FAIL sub1_timeout got=timeout exp=out_valid"); end
        if (rs !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub1_sum got=%h exp=fffffffffffffffe", rs); end
        if (rc !== 1'b0) begin bad++; $display("FAIL sub1_cout got=%b exp=0", rc); end
        run_op(1'b0, 64'd7, 64'd5, 1'b1, 1'b0, 2, rs, rc, lat, tmo);
        total += 3;
        if (tmo) begin bad++; $display("FAIL sub2_timeout got=timeout exp=out_valid"); end
        if (rs !== 64'd2) begin bad++; $display("FAIL sub2_sum got=%h exp=2", rs); end
        if (rc !== 1'b1) begin bad++; $display("FAIL sub2_cout got=%b exp=1", rc); end
    endtask
`endif

    task automatic test_random(input bit w16, input int count);
        logic [63:0] ta, tb, rs, exp_sum, mask;
        logic [64:0] full;
        logic        rc, exp_c;
        bit          tsub, hold, tmo;
        int          lat, exp_lat, sel;
        mask    = w16 ? 64'h0000_0000_0000_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        exp_lat = w16 ? 1 : 4;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 7);
            ta  = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            tb  = (sel == 1) ? 64'h1 : (sel == 2) ? 64'h0 : {$urandom, $urandom};
            ta  = ta & mask;
            tb  = tb & mask;
`ifdef WIDE_ADDER_SEQ_SUB_EN
            tsub = $urandom_range(0, 1) == 1;
`else
            tsub = 1'b0;
`endif
            hold = ($urandom_range(0, 3) == 0);
            run_op(w16, ta, tb, tsub, hold, $urandom_range(0, 3), rs, rc, lat, tmo);
            if (tsub) begin
                exp_sum = (ta - tb) & mask;
                exp_c   = (ta >= tb);
            end else begin
                full    = {1'b0, ta} + {1'b0, tb};
                exp_sum = full[63:0] & mask;
                exp_c   = w16 ? full[16] : full[64];
            end
            total += 4;
            if (tmo) begin bad++; $display("FAIL rand%0d_timeout[%0d] got=timeout exp=out_valid", w16 ? 16 : 64, i); end
            if (lat != exp_lat) begin bad++; $display("FAIL rand%0d_latency[%0d] got=%0d exp=%0d", w16 ? 16 : 64, i, lat, exp_lat); end
            if (rs !== exp_sum) begin bad++; $display("FAIL rand%0d_sum[%0d] a=%h b=%h sub=%b got=%h exp=%h", w16 ? 16 : 64, i, ta, tb, tsub, rs, exp_sum); end
            if (rc !== exp_c) begin bad++; $display("FAIL rand%0d_cout[%0d] a=%h b=%h sub=%b got=%b exp=%b", w16 ? 16 : 64, i, ta, tb, tsub, rc, exp_c); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        a           = '0;
        b           = '0;
`ifdef WIDE_ADDER_SEQ_SUB_EN
        op_sub      = 1'b0;
`endif
        in_valid64  = 1'b0;
        out_ready64 = 1'b0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        test_reset();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_op();
`ifdef WIDE_ADDER_SEQ_SUB_EN
        test_sub();
`endif
        test_random(1'b0, 1000);
        test_random(1'b1, 1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
